// File: rtl/cdb_arbiter_if.sv
// Source-side and broadcast-side signals of the CDB arbiter.
// master: the functional units plus flush control; slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6
);
  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  logic                     flush;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [NUM_SRC*XLEN-1:0]  src_data;
  logic [NUM_SRC*TAG_W-1:0] src_tag;
  logic                     cdb_valid;
  logic [XLEN-1:0]          cdb_data;
  logic [TAG_W-1:0]         cdb_tag;
  logic [SRC_W-1:0]         cdb_src;

  modport master (
    output flush, src_valid, src_data, src_tag,
    input  src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );

  modport slave (
    input  flush, src_valid, src_data, src_tag,
    output src_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per source, round-robin broadcast, flush drop.
// Define CDB_BYPASS_EN to send a result straight to the CDB when every slot is empty.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  typedef logic [SRC_W-1:0] idx_t;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] req, input idx_t ptr);
    logic found;
    idx_t win;
    int   idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      idx = (int'(ptr) + k) % int'(NUM_SRC);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx_t'(idx);
      end
    end
    return {found, win};
  endfunction

  function automatic idx_t next_ptr(input idx_t g);
    return idx_t'((int'(g) + 1) % int'(NUM_SRC));
  endfunction

  logic [NUM_SRC-1:0] slot_valid_q, slot_valid_d;
  logic [XLEN-1:0]    slot_data_q [NUM_SRC];
  logic [XLEN-1:0]    slot_data_d [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag_q  [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag_d  [NUM_SRC];
  idx_t               rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [XLEN-1:0]    cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  idx_t               cdb_src_q, cdb_src_d;

  logic [SRC_W:0]     grant_pick;
  logic               grant_vld;
  idx_t               grant_idx;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] accept;
  logic               byp_vld;
  idx_t               byp_idx;
  logic [NUM_SRC-1:0] byp_take;

  assign grant_pick = rr_pick(slot_valid_q, rr_ptr_q);
  assign grant_vld  = grant_pick[SRC_W];
  assign grant_idx  = grant_pick[SRC_W-1:0];
  assign grant      = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;

  // A slot being granted this cycle can take a new result on the same edge.
  assign src_ready  = {NUM_SRC{!bus.flush}} & (~slot_valid_q | grant);
  assign accept     = bus.src_valid & src_ready;

`ifdef CDB_BYPASS_EN
  logic [SRC_W:0] byp_pick;
  assign byp_pick = rr_pick(accept, rr_ptr_q);
  assign byp_vld  = ~|slot_valid_q && byp_pick[SRC_W];
  assign byp_idx  = byp_pick[SRC_W-1:0];
`else
  assign byp_vld  = 1'b0;
  assign byp_idx  = '0;
`endif
  assign byp_take = byp_vld ? (NUM_SRC'(1) << byp_idx) : '0;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    slot_tag_d   = slot_tag_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = 1'b0;
    cdb_data_d   = cdb_data_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_src_d    = cdb_src_q;
    if (bus.flush) begin
      slot_valid_d = '0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (accept[i] && !byp_take[i]) begin
          slot_valid_d[i] = 1'b1;
          slot_data_d[i]  = bus.src_data[i*XLEN +: XLEN];
          slot_tag_d[i]   = bus.src_tag[i*TAG_W +: TAG_W];
        end else if (grant[i]) begin
          slot_valid_d[i] = 1'b0;
        end
      end
      if (grant_vld) begin
        cdb_valid_d = 1'b1;
        cdb_data_d  = slot_data_q[grant_idx];
        cdb_tag_d   = slot_tag_q[grant_idx];
        cdb_src_d   = grant_idx;
        rr_ptr_d    = next_ptr(grant_idx);
      end else if (byp_vld) begin
        cdb_valid_d = 1'b1;
        cdb_data_d  = bus.src_data[byp_idx*XLEN +: XLEN];
        cdb_tag_d   = bus.src_tag[byp_idx*TAG_W +: TAG_W];
        cdb_src_d   = byp_idx;
        rr_ptr_d    = next_ptr(byp_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        slot_data_q[i] <= '0;
        slot_tag_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_tag_q   <= slot_tag_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts queued at stimulus, popped on cdb_valid.
module tb_cdb_arbiter;
  localparam int unsigned NumSrc = 4;
  localparam int unsigned Xlen   = 32;
  localparam int unsigned TagW   = 6;
  localparam int          K      = 6;
`ifdef CDB_BYPASS_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(NumSrc), .XLEN(Xlen), .TAG_W(TagW)) bus ();

  cdb_arbiter #(.NUM_SRC(NumSrc), .XLEN(Xlen), .TAG_W(TagW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic [1:0]  src;
  } bc_t;

  bc_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt[2];
  int   lowcnt;
  int   guard;
  logic [3:0] acc;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    bc_t e;
    if (rst_n && bus.cdb_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("cdb_unexpected", 64'(bus.cdb_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("cdb_data", 64'(bus.cdb_data), 64'(e.data));
        check_eq("cdb_tag", 64'(bus.cdb_tag), 64'(e.tag));
        check_eq("cdb_src", 64'(bus.cdb_src), 64'(e.src));
      end
    end
  end

  task automatic put(input int i, input logic [31:0] d, input logic [5:0] t);
    bus.src_valid[i]              = 1'b1;
    bus.src_data[i*Xlen +: Xlen]  = d;
    bus.src_tag[i*TagW +: TagW]   = t;
  endtask

  task automatic expect_bc(input logic [31:0] d, input logic [5:0] t, input logic [1:0] s);
    sb_q.push_back('{data: d, tag: t, src: s});
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    bus.src_valid = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cdb(input int n, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < n && !seen; c++) begin
      @(negedge clk);
      if (bus.cdb_valid) seen = 1'b1;
    end
    if (!seen) check_eq("cdb_timeout", 64'(seen), 64'd1);
  endtask

  logic seen;

  initial begin
    bus.flush     = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_tag   = '0;

    // Power-on reset values
    repeat (2) @(negedge clk);
    check_eq("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check_eq("rst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    check_eq("rst_cdb_data", 64'(bus.cdb_data), 64'd0);
    check_eq("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
    check_eq("rst_src_ready", 64'(bus.src_ready), 64'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single result from source 2, latency check
    put(2, 32'hDEAD_BEEF, 6'd9);
    expect_bc(32'hDEAD_BEEF, 6'd9, 2'd2);
    pulse();
    @(negedge clk);
    check_eq("single_lat_e1", 64'(bus.cdb_valid), 64'(Lat == 1));
    @(negedge clk);
    check_eq("single_lat_e2", 64'(bus.cdb_valid), 64'(Lat == 2));
    drain(4);

    // Wrap-around: rr_ptr=3, sources 3 and 0
    put(3, 32'h3333_0003, 6'd33);
    put(0, 32'h3333_0000, 6'd30);
    expect_bc(32'h3333_0003, 6'd33, 2'd3);
    expect_bc(32'h3333_0000, 6'd30, 2'd0);
    pulse();
    drain(5);

    // rr_ptr must now be 1: source 1 beats source 0
    put(0, 32'h4444_0000, 6'd40);
    put(1, 32'h4444_0001, 6'd41);
    expect_bc(32'h4444_0001, 6'd41, 2'd1);
    expect_bc(32'h4444_0000, 6'd40, 2'd0);
    pulse();
    drain(5);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) begin
      put(i, 32'h5555_0000 + 32'(i), 6'(50 + i));
      expect_bc(32'h5555_0000 + 32'(i), 6'(50 + i), 2'(i));
    end
    pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check_eq("midrst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    check_eq("midrst_src_ready", 64'(bus.src_ready), 64'hF);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("no_stale", 64'(bus.cdb_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Round-robin fairness from rr_ptr=0, tags 1..4, no gaps
    for (int i = 0; i < 4; i++) begin
      put(i, 32'h1000_0000 + 32'(i), 6'(i + 1));
      expect_bc(32'h1000_0000 + 32'(i), 6'(i + 1), 2'(i));
    end
    pulse();
    wait_cdb(6, seen);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rr_nogap", 64'(bus.cdb_valid), 64'd1);
    end
    drain(3);

    // Backpressure: sources 0 and 1 stream continuously
    cnt[0] = 0;
    cnt[1] = 0;
    lowcnt = 0;
    guard  = 0;
    put(0, 32'hA000_0000, 6'd10);
    put(1, 32'hB000_0000, 6'd40);
    for (int k = 0; k < K; k++) begin
      expect_bc(32'hA000_0000 + 32'(k), 6'(10 + k), 2'd0);
      expect_bc(32'hB000_0000 + 32'(k), 6'(40 + k), 2'd1);
    end
    while ((cnt[0] < K || cnt[1] < K) && guard < 40) begin
      @(negedge clk);
      acc = bus.src_valid & bus.src_ready;
      if (bus.src_valid[0] && !bus.src_ready[0]) lowcnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          cnt[i]++;
          if (cnt[i] == K) bus.src_valid[i] = 1'b0;
          else if (i == 0) put(0, 32'hA000_0000 + 32'(cnt[0]), 6'(10 + cnt[0]));
          else put(1, 32'hB000_0000 + 32'(cnt[1]), 6'(40 + cnt[1]));
        end
      end
      guard++;
    end
    check_eq("bp_accepted", 64'(cnt[0] + cnt[1]), 64'(2 * K));
    check_eq("bp_ready_low", 64'(lowcnt >= K - 3), 64'd1);
    drain(6);

    // Flush with three slots full; source 3 tries during the flush cycle
`ifdef CDB_BYPASS_EN
    for (int i = 0; i < 4; i++) put(i, 32'h6666_0000 + 32'(i), 6'(60 + i));
    expect_bc(32'h6666_0002, 6'd62, 2'd2);
`else
    for (int i = 0; i < 3; i++) put(i, 32'h6666_0000 + 32'(i), 6'(60 + i));
`endif
    pulse();
    bus.flush = 1'b1;
    put(3, 32'h7777_0003, 6'd63);
    @(negedge clk);
    check_eq("flush_src_ready", 64'(bus.src_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.src_valid = '0;
    @(negedge clk);
    check_eq("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    drain(8);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter that collects completed results from the functional units and broadcasts one result per cycle onto the CDB. The CDB feeds the reorder buffer's result port (`result_data`/`result_tag`/`result_valid`) and the reservation-station tag snoop. Each source has a one-entry holding slot, and sources are served with round-robin fairness. A flush discards every held and in-flight result.

## Interface
- `NUM_SRC`, default 4: number of functional-unit sources, 2..8.
- `XLEN`, default 32: result data width.
- `TAG_W`, default 6: ROB tag width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `src_valid` input NUM_SRC: source i presents a result.
- `src_ready` output NUM_SRC: source i's result is accepted this cycle.
- `src_data` input NUM_SRC*XLEN: packed result data; source i occupies bits [i*XLEN +: XLEN].
- `src_tag` input NUM_SRC*TAG_W: packed ROB tags; same packing as `src_data`.
- `cdb_valid` output 1: broadcast valid.
- `cdb_data` output XLEN: broadcast data.
- `cdb_tag` output TAG_W: broadcast ROB tag.
- `cdb_src` output clog2(NUM_SRC): index of the source that won, for debug.

The clock is `clk` and the reset is `rst_n`, asynchronous and active-low, as decided for this block.

## Operation
- **Slots.** Per source: `slot_valid[i]`, `slot_data[i]`, `slot_tag[i]`.
- **Accept.** A source result is accepted when `src_valid[i] && src_ready[i]` at a rising edge, and is written into slot i.
- **Ready.** `src_ready[i] = !flush && (!slot_valid[i] || grant[i])`. A slot can drain and refill on the same edge.
- **Grant.** Combinational round-robin over `slot_valid`, starting the search at `rr_ptr` and wrapping modulo NUM_SRC. At most one grant per cycle.
- **Output.** On an edge with a grant to source g:
  - `cdb_valid<=1`, `cdb_data<=slot_data[g]`, `cdb_tag<=slot_tag[g]`, `cdb_src<=g`.
  - `slot_valid[g]` clears unless it is refilled on the same edge.
  - `rr_ptr<=(g+1)%NUM_SRC`.
- **No grant.** `cdb_valid<=0`. `cdb_data`, `cdb_tag` and `cdb_src` hold their values. `rr_ptr` holds.
- **No downstream backpressure.** The ROB always accepts a CDB broadcast.
- **Flush.** At an edge with `flush=1`:
  - All `slot_valid<=0` and `cdb_valid<=0`. `rr_ptr` holds.
  - No source result is accepted in the flush cycle, because `src_ready` is 0.
- **Reset.** All slots empty. `rr_ptr=0`, `cdb_valid=0`, `cdb_data=0`, `cdb_tag=0`, `cdb_src=0`, `src_ready` all 1.
- **Data integrity.** Tags and data pass through unmodified. No result is duplicated. No accepted result is dropped except by flush or reset.

## Timing
- **Base latency.** A result accepted at edge E0 can be granted in the cycle after E0, loaded at E1, and is visible on the CDB during the cycle after E1. That is 2 edges from handshake to broadcast when uncontended.
- **Throughput.** One broadcast per cycle. With all NUM_SRC slots full, every source is granted within NUM_SRC cycles.
- **Steady streaming.** A source streaming every cycle with no contention sustains 1 result/cycle, because its slot drains and refills on the same edge.
- **Reset mid-operation.** Reset takes effect asynchronously. Outputs go to their reset values immediately, and held results are lost.
- **Flush and grant together.** Flush wins: `cdb_valid` is 0 on the next cycle.

## Configuration
- **`CDB_BYPASS_EN` defined.**
  - At an edge where every slot is empty and at least one source handshakes, the round-robin winner among the handshaking sources goes directly to the output registers without occupying its slot.
  - The remaining handshaking sources are captured into their slots, and `rr_ptr` updates to winner+1.
  - Uncontended latency becomes 1 edge.
- **`CDB_BYPASS_EN` undefined.** Every result passes through its slot, and latency is always at least 2 edges.
- **Either way.** Flush still forces `src_ready=0` and `cdb_valid<=0`.

## Test plan
- **Reset values.** Assert `rst_n=0` mid-stream -> `cdb_valid=0`, `cdb_tag=0`, `src_ready=4'b1111`, and no stale broadcast after release.
- **Single result.** Source 2 sends data 0xDEAD_BEEF, tag 6'd9, for one cycle -> exactly one broadcast `cdb_tag=9`, `cdb_data=0xDEADBEEF`, `cdb_src=2`, 2 edges later (1 edge with `CDB_BYPASS_EN`).
- **Round-robin fairness.** All 4 sources valid on the same cycle with tags 1, 2, 3, 4 from `rr_ptr=0` -> broadcasts tags 1, 2, 3, 4 in that order on consecutive cycles, with no gaps.
- **Backpressure.** Sources 0 and 1 stream every cycle -> CDB alternates 0, 1, 0, 1. Each source sees `src_ready` low on alternate cycles, and no tag is lost or repeated.
- **Flush.** Three slots full, assert `flush` for one cycle -> `cdb_valid=0` on the following cycle. No flushed tag is ever broadcast, and `src_ready=0` during the flush cycle.
- **Wrap-around.** `NUM_SRC=4`, `rr_ptr=3`, sources 3 and 0 valid -> source 3 is granted, then source 0, and `rr_ptr` ends at 1.
